alu_issue: RTL and testbench

- Issue/writeback stage directly upstream and downstream of the 16-bit ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 16x16 register file.
- Drives the ALU's r1/r2/opcode inputs, captures the ALU result (rout), writes it back to the register file and updates Z/N status flags.
- Instructions are strictly serialised, so no hazard logic is needed.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/regfile16.sv | 38 +++
 rtl/alu_issue.sv | 122 ++++++++++++
 tb/tb_alu_issue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the ALU issue/writeback stage: opcodes, instruction
// field positions, FSM encoding and the opcode legality check.
package cpu_pkg;

  localparam int unsigned NREGS_DEF = 16;
  localparam int unsigned WIDTH_DEF = 16;

  // 8-bit ALU opcodes, formed as {op_hi, op_ext}
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_MULT = 8'h0E;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  // Instruction word fields: [15:12] op_hi, [11:8] rdest, [7:4] op_ext, [3:0] rsrc
  localparam int unsigned OP_HI_LSB  = 12;
  localparam int unsigned RDEST_LSB  = 8;
  localparam int unsigned OP_EXT_LSB = 4;
  localparam int unsigned RSRC_LSB   = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU, OP_ADDC, OP_RSH,
      OP_SUB, OP_SUBC, OP_CMP, OP_ALSH, OP_MULT, OP_ARSH, OP_LSH: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/regfile16.sv
// 16x16 register file: one synchronous write port, two combinational operand
// read ports and a combinational debug read port.
module regfile16 #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr_a_i,
  output logic [WIDTH-1:0]         rdata_a_o,
  input  logic [$clog2(NREGS)-1:0] raddr_b_i,
  output logic [WIDTH-1:0]         rdata_b_o,
  input  logic [$clog2(NREGS)-1:0] dbg_addr_i,
  output logic [WIDTH-1:0]         dbg_data_o
);

  logic [WIDTH-1:0] mem_q [NREGS];

  // Register storage with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports are plain muxes; no write-through bypass is needed
  always_comb begin
    rdata_a_o  = mem_q[raddr_a_i];
    rdata_b_o  = mem_q[raddr_b_i];
    dbg_data_o = mem_q[dbg_addr_i];
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage around an external combinational 16-bit ALU.
// Serialises instructions IDLE -> EXEC -> WB, so no hazard logic exists.
module alu_issue
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [15:0]              instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  output logic [WIDTH-1:0]         alu_r1,
  output logic [WIDTH-1:0]         alu_r2,
  output logic [7:0]               alu_opcode,
  input  logic [WIDTH-1:0]         alu_rout,
  output logic                     done,
  output logic                     illegal,
  output logic                     flag_z,
  output logic                     flag_n,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int unsigned AW = $clog2(NREGS);

  state_e           state_q;
  logic [WIDTH-1:0] alu_r1_q, alu_r2_q, result_q;
  logic [7:0]       alu_opcode_q;
  logic [AW-1:0]    rdest_q;
  logic             done_q, illegal_q, flag_z_q, flag_n_q;

  logic [AW-1:0]    instr_rdest, instr_rsrc;
  logic [7:0]       instr_op;
  logic [WIDTH-1:0] rd_dest, rd_src;
  logic             op_legal, rf_we;

  // Decode the incoming word and the write-back qualifiers
  always_comb begin
    instr_rdest = instr[RDEST_LSB +: AW];
    instr_rsrc  = instr[RSRC_LSB +: AW];
    instr_op    = {instr[OP_HI_LSB +: 4], instr[OP_EXT_LSB +: 4]};
    op_legal    = is_legal_op(alu_opcode_q);
    rf_we       = (state_q == StWb) && op_legal && (alu_opcode_q != OP_CMP);
  end

  regfile16 #(
    .NREGS(NREGS),
    .WIDTH(WIDTH)
  ) u_regfile (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .we_i       (rf_we),
    .waddr_i    (rdest_q),
    .wdata_i    (result_q),
    .raddr_a_i  (instr_rdest),
    .rdata_a_o  (rd_dest),
    .raddr_b_i  (instr_rsrc),
    .rdata_b_o  (rd_src),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Control FSM with registered operand, status and pulse outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      alu_r1_q     <= '0;
      alu_r2_q     <= '0;
      alu_opcode_q <= '0;
      rdest_q      <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            alu_r1_q     <= rd_dest;
            alu_r2_q     <= rd_src;
            alu_opcode_q <= instr_op;
            rdest_q      <= instr_rdest;
            state_q      <= StExec;
          end
        end
        StExec: begin
          // done/illegal are raised here so they are visible for the whole WB cycle
          result_q  <= alu_rout;
          done_q    <= 1'b1;
          illegal_q <= !op_legal;
          state_q   <= StWb;
        end
        StWb: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          if (op_legal) begin
            flag_z_q <= (result_q == '0);
            flag_n_q <= result_q[WIDTH-1];
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output mapping
  always_comb begin
    instr_ready = (state_q == StIdle);
    alu_r1      = alu_r1_q;
    alu_r2      = alu_r2_q;
    alu_opcode  = alu_opcode_q;
    done        = done_q;
    illegal     = illegal_q;
    flag_z      = flag_z_q;
    flag_n      = flag_n_q;
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue; the bench also plays the external ALU.
module tb_alu_issue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_r1, alu_r2, alu_rout, dbg_data;
  logic [7:0]  alu_opcode;
  logic        done, illegal, flag_z, flag_n;
  logic [3:0]  dbg_addr;

  logic        force_en;
  logic [15:0] force_val;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          base;

  always #5 clock = ~clock;

  alu_issue dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_r1      (alu_r1),
    .alu_r2      (alu_r2),
    .alu_opcode  (alu_opcode),
    .alu_rout    (alu_rout),
    .done        (done),
    .illegal     (illegal),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  function automatic logic [15:0] alu_model(input logic [7:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    case (op)
      8'h01:        return a & b;
      8'h02:        return a | b;
      8'h03:        return a ^ b;
      8'h04:        return ~a;
      8'h05:        return a + b;
      8'h09, 8'h0B: return a - b;
      default:      return 16'h5A5A;
    endcase
  endfunction

  assign alu_rout = force_en ? force_val : alu_model(alu_opcode, alu_r1, alu_r2);

  always @(posedge clock) if (done === 1'b1) done_cnt++;

  function automatic logic [15:0] mk(input logic [7:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs);
    return {op[7:4], rd, op[3:0], rs};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Present a word and return at the negedge inside EXEC
  task automatic issue_exec(input logic [15:0] w);
    int n;
    @(negedge clock);
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (instr_ready !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (instr_ready !== 1'b1) check("ready_timeout", {15'd0, instr_ready}, 16'd1);
    @(posedge clock);
    #1 instr_valid = 1'b0;
    @(negedge clock);
  endtask

  // Load a register with an arbitrary value by forcing the ALU result
  task automatic preload(input logic [3:0] rd, input logic [15:0] v);
    force_en = 1'b1;
    force_val = v;
    issue_exec(mk(8'h01, rd, rd));
    @(negedge clock);
    @(negedge clock);
    force_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    dbg_addr = '0;
    force_en = 1'b0;
    force_val = '0;
    repeat (2) @(negedge clock);
    check("rst_r1", alu_r1, 16'h0);
    check("rst_r2", alu_r2, 16'h0);
    check("rst_opcode", {8'd0, alu_opcode}, 16'h0);
    check("rst_done_ill", {14'd0, done, illegal}, 16'h0);
    check("rst_flags", {14'd0, flag_z, flag_n}, 16'h0);
    reset_n = 1'b1;

    // Reset during EXEC aborts the instruction
    preload(4'd7, 16'h1234);
    rd_chk("pre_r7", 4'd7, 16'h1234);
    base = done_cnt;
    issue_exec(16'h0752);
    reset_n = 1'b0;
    #1;
    check("abort_opcode", {8'd0, alu_opcode}, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("abort_ready", {15'd0, instr_ready}, 16'd1);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("abort_R%0d", i), i[3:0], 16'h0);
    repeat (3) @(negedge clock);
    check("abort_no_done", done_cnt[15:0], base[15:0]);

    // ADD R1 = 3 + 1
    preload(4'd1, 16'd3);
    preload(4'd2, 16'd1);
    preload(4'd3, 16'd1);
    preload(4'd4, 16'd2);
    preload(4'd5, 16'h00A5);
    issue_exec(16'h0152);
    check("add_opcode", {8'd0, alu_opcode}, 16'h0005);
    check("add_r1", alu_r1, 16'd3);
    check("add_r2", alu_r2, 16'd1);
    check("add_exec_done", {15'd0, done}, 16'd0);
    @(negedge clock);
    check("add_done", {14'd0, done, illegal}, 16'b10);
    rd_chk("add_r1_before_wb", 4'd1, 16'd3);
    @(negedge clock);
    check("add_done_clear", {15'd0, done}, 16'd0);
    rd_chk("add_R1", 4'd1, 16'd4);
    check("add_flags", {14'd0, flag_z, flag_n}, 16'b00);

    // CMP R3,R4: flags only
    issue_exec(16'h03B4);
    @(negedge clock);
    @(negedge clock);
    rd_chk("cmp_R3", 4'd3, 16'd1);
    check("cmp_flags", {14'd0, flag_z, flag_n}, 16'b01);

    // Illegal opcode 0x0D
    issue_exec(16'h00D0);
    @(negedge clock);
    check("ill_pulse", {14'd0, done, illegal}, 16'b11);
    @(negedge clock);
    check("ill_clear", {15'd0, illegal}, 16'd0);
    rd_chk("ill_R0", 4'd0, 16'h0);
    check("ill_flags", {14'd0, flag_z, flag_n}, 16'b01);

    // LSH (0x84) is legal and writes back
    issue_exec(mk(8'h84, 4'd6, 4'd6));
    @(negedge clock);
    check("lsh_illegal", {14'd0, done, illegal}, 16'b10);
    @(negedge clock);
    rd_chk("lsh_R6", 4'd6, 16'h5A5A);
    check("lsh_flags", {14'd0, flag_z, flag_n}, 16'b00);

    // Back-to-back XOR R5,R5 then NOT R5 with valid held high
    @(negedge clock);
    instr = 16'h0535;
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr = 16'h0545;
    @(negedge clock);
    check("b2b_rdy_exec1", {15'd0, instr_ready}, 16'd0);
    check("b2b_xor_r1", alu_r1, 16'h00A5);
    @(negedge clock);
    check("b2b_rdy_wb1", {15'd0, instr_ready}, 16'd0);
    @(negedge clock);
    check("b2b_rdy_idle", {15'd0, instr_ready}, 16'd1);
    rd_chk("b2b_R5_xor", 4'd5, 16'h0000);
    check("b2b_xor_flags", {14'd0, flag_z, flag_n}, 16'b10);
    @(negedge clock);
    instr_valid = 1'b0;
    check("b2b_rdy_exec2", {15'd0, instr_ready}, 16'd0);
    check("b2b_not_opcode", {8'd0, alu_opcode}, 16'h0004);
    check("b2b_not_r1", alu_r1, 16'h0000);
    @(negedge clock);
    check("b2b_rdy_wb2", {15'd0, instr_ready}, 16'd0);
    @(negedge clock);
    rd_chk("b2b_R5_not", 4'd5, 16'hFFFF);
    check("b2b_not_flags", {14'd0, flag_z, flag_n}, 16'b01);

    // Valid pulsed with another word while busy is ignored
    base = done_cnt;
    issue_exec(mk(8'h02, 4'd8, 4'd2));
    instr = mk(8'h04, 4'd9, 4'd9);
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    repeat (4) @(negedge clock);
    rd_chk("hold_R8", 4'd8, 16'd1);
    rd_chk("hold_R9", 4'd9, 16'd0);
    check("hold_done_cnt", done_cnt[15:0], base[15:0] + 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
